// File: rtl/instr_dispatch_arbiter_if.sv
// Dispatch bus: one instruction input port feeding NUM_LANES output lanes.
// The arbiter uses the slave modport; the upstream/downstream side uses master.
interface instr_dispatch_arbiter_if #(
    parameter int DATA_W    = 32,
    parameter int NUM_LANES = 2,
    parameter int DEPTH     = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0]           in_instr;
    logic                        in_valid;
    logic                        in_ready;
    logic [NUM_LANES*DATA_W-1:0] out_instr;
    logic [NUM_LANES-1:0]        out_valid;
    logic [NUM_LANES-1:0]        out_ready;
    logic                        hazard_stall;
    logic [NUM_LANES*CNT_W-1:0]  lane_count;

    modport master (
        output in_instr, in_valid, out_ready,
        input  in_ready, out_instr, out_valid, hazard_stall, lane_count
    );

    modport slave (
        input  in_instr, in_valid, out_ready,
        output in_ready, out_instr, out_valid, hazard_stall, lane_count
    );
endinterface

// File: rtl/instr_dispatch_arbiter.sv
// Instruction dispatch arbiter: routes each incoming instruction to one of
// NUM_LANES FIFOs, keeping register-dependent instructions in the lane that
// already holds their producer/consumer, otherwise balancing lane occupancy.
module instr_dispatch_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 9,
    parameter int NUM_LANES = 2,
    parameter int DEPTH     = 4
) (
    input logic                     clk,
    input logic                     resetn,
    instr_dispatch_arbiter_if.slave bus
);
    localparam int LANE_W = $clog2(NUM_LANES);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int ND_W   = LANE_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    // Per-lane FIFO storage; each slot's SRC/DST fields double as the
    // dependency tracking entry, qualified by its valid bit.
    logic [DATA_W-1:0] mem_q   [NUM_LANES][DEPTH];
    logic [DEPTH-1:0]  vld_q   [NUM_LANES];
    logic [PTR_W-1:0]  wr_q    [NUM_LANES];
    logic [PTR_W-1:0]  rd_q    [NUM_LANES];
    logic [CNT_W-1:0]  count_q [NUM_LANES];

    // Decoded fields of the offered instruction.
    logic              ovr;
    logic [LANE_W-1:0] ovr_lane;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;

    assign ovr      = bus.in_instr[28];
    assign ovr_lane = bus.in_instr[27 -: LANE_W];
    assign src      = bus.in_instr[2*ADDR_W-1:ADDR_W];
    assign dst      = bus.in_instr[ADDR_W-1:0];

    logic [NUM_LANES-1:0] dep;
    logic [ND_W-1:0]      num_dep;
    logic [LANE_W-1:0]    dep_lane;
    logic [LANE_W-1:0]    min_lane;
    logic [LANE_W-1:0]    target;
    logic                 stall_route;
    logic                 in_ready;
    logic                 push;
    logic [NUM_LANES-1:0] push_lane;
    logic [NUM_LANES-1:0] pop;

    // Dependency check of the incoming SRC/DST against every valid tracked entry.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch can be inferred.
        dep     = '0;
        num_dep = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (vld_q[k][e] &&
                    ((src == mem_q[k][e][2*ADDR_W-1:ADDR_W]) || (src == mem_q[k][e][ADDR_W-1:0]) ||
                     (dst == mem_q[k][e][2*ADDR_W-1:ADDR_W]) || (dst == mem_q[k][e][ADDR_W-1:0]))) begin
                    dep[k] = 1'b1;
                end
            end
            num_dep = num_dep + ND_W'(dep[k]);
        end
    end

    // Route selection: multi-lane hazard, override, single dependency, then least occupied lane.
    always_comb begin
        dep_lane = '0;
        min_lane = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (dep[k]) dep_lane = LANE_W'(k);
        end
        for (int k = 1; k < NUM_LANES; k++) begin
            if (count_q[k] < count_q[min_lane]) min_lane = LANE_W'(k);
        end
        stall_route = 1'b0;
        target      = min_lane;
        if (num_dep >= ND_W'(2)) begin
            stall_route = 1'b1;
        end else if (ovr) begin
            if ((num_dep == '0) || dep[ovr_lane]) target = ovr_lane;
            else stall_route = 1'b1;
        end else if (num_dep == ND_W'(1)) begin
            target = dep_lane;
        end
    end

    // Handshakes: a full target stalls even if it pops this cycle.
    always_comb begin
        in_ready = resetn && !stall_route && (count_q[target] < FULL);
        push     = bus.in_valid && in_ready;
        for (int k = 0; k < NUM_LANES; k++) begin
            push_lane[k] = push && (target == LANE_W'(k));
            pop[k]       = (count_q[k] != '0) && bus.out_ready[k];
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.hazard_stall = resetn && bus.in_valid && !in_ready;

    // Lane heads, valid flags and occupancy come straight from registered state.
    always_comb begin
        for (int k = 0; k < NUM_LANES; k++) begin
            bus.out_instr[k*DATA_W +: DATA_W] = mem_q[k][rd_q[k]];
            bus.out_valid[k]                  = (count_q[k] != '0);
            bus.lane_count[k*CNT_W +: CNT_W]  = count_q[k];
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        // Lane control: pointers, occupancy and tracking valid bits.
        always_ff @(posedge clk) begin
            if (!resetn) begin
                count_q[k] <= '0;
                wr_q[k]    <= '0;
                rd_q[k]    <= '0;
                vld_q[k]   <= '0;
            end else begin
                if (push_lane[k]) begin
                    vld_q[k][wr_q[k]] <= 1'b1;
                    wr_q[k]           <= wr_q[k] + PTR_W'(1);
                end
                if (pop[k]) begin
                    vld_q[k][rd_q[k]] <= 1'b0;
                    rd_q[k]           <= rd_q[k] + PTR_W'(1);
                end
                count_q[k] <= count_q[k] + CNT_W'(push_lane[k]) - CNT_W'(pop[k]);
            end
        end

        // Lane payload write.
        always_ff @(posedge clk) begin
            // NOTE: the payload array is not reset; vld_q and count_q decide what is visible, so stale data never leaks.
            if (push_lane[k]) mem_q[k][wr_q[k]] <= bus.in_instr;
        end
    end
endmodule

// File: tb/tb_instr_dispatch_arbiter.sv
// Self-checking bench for instr_dispatch_arbiter (2 lanes, depth 4).
// Directed table, hand-written corner sequences and random traffic, all
// compared against a queue-style reference model of the lanes.
module tb_instr_dispatch_arbiter;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 9;
    localparam int NUM_LANES = 2;
    localparam int DEPTH     = 4;
    localparam int CNT_W     = 3;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    instr_dispatch_arbiter_if #(.DATA_W(DATA_W), .NUM_LANES(NUM_LANES), .DEPTH(DEPTH)) bus ();

    instr_dispatch_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_LANES(NUM_LANES), .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: each lane is an ordered list, head at index 0.
    logic [31:0] mq [NUM_LANES][DEPTH];
    int          mcnt [NUM_LANES];
    bit          model_known = 1'b0;
    logic        smp_ready;
    logic        smp_stall;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Decide acceptance and target lane from the routing rules and model contents.
    task automatic model_route(input logic [31:0] ins, output logic rdy, output int tgt);
        logic [8:0] s, d, es, ed;
        logic [1:0] dep;
        int ndep, dlane, lane;
        s = ins[17:9];
        d = ins[8:0];
        dep = '0;
        ndep = 0;
        dlane = 0;
        for (int k = 0; k < NUM_LANES; k++)
            for (int j = 0; j < mcnt[k]; j++) begin
                es = mq[k][j][17:9];
                ed = mq[k][j][8:0];
                if (s == es || s == ed || d == es || d == ed) dep[k] = 1'b1;
            end
        for (int k = 0; k < NUM_LANES; k++)
            if (dep[k]) begin ndep++; dlane = k; end
        lane = int'(ins[27]);
        rdy = 1'b1;
        tgt = 0;
        if (ndep >= 2) rdy = 1'b0;
        else if (ins[28]) begin
            if (ndep == 0 || dep[lane]) tgt = lane;
            else rdy = 1'b0;
        end else if (ndep == 1) tgt = dlane;
        else tgt = (mcnt[1] < mcnt[0]) ? 1 : 0;
        if (rdy && mcnt[tgt] >= DEPTH) rdy = 1'b0;
    endtask

    // One cycle: drive at negedge, compare registered and combinational outputs, advance model at posedge.
    task automatic apply(input logic rn, input logic v, input logic [31:0] ins, input logic [1:0] ordy);
        logic exp_rdy;
        int   tgt;
        @(negedge clk);
        resetn       = rn;
        bus.in_valid = v;
        bus.in_instr = ins;
        bus.out_ready = ordy;
        #1;
        if (model_known) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                check($sformatf("lane%0d out_valid", k), bus.out_valid[k], mcnt[k] != 0);
                check($sformatf("lane%0d count", k), bus.lane_count[k*CNT_W +: CNT_W], mcnt[k]);
                if (mcnt[k] > 0)
                    check($sformatf("lane%0d head", k), bus.out_instr[k*DATA_W +: DATA_W], mq[k][0]);
            end
        end
        model_route(ins, exp_rdy, tgt);
        if (!rn) exp_rdy = 1'b0;
        if (model_known || !rn) begin
            check("in_ready", bus.in_ready, exp_rdy);
            check("hazard_stall", bus.hazard_stall, rn && v && !exp_rdy);
        end
        smp_ready = bus.in_ready;
        smp_stall = bus.hazard_stall;
        @(posedge clk);
        if (!rn) begin
            for (int k = 0; k < NUM_LANES; k++) mcnt[k] = 0;
            model_known = 1'b1;
        end else begin
            for (int k = 0; k < NUM_LANES; k++)
                if (mcnt[k] > 0 && ordy[k]) begin
                    for (int j = 0; j < DEPTH - 1; j++) mq[k][j] = mq[k][j+1];
                    mcnt[k]--;
                end
            if (v && exp_rdy) begin
                mq[tgt][mcnt[tgt]] = ins;
                mcnt[tgt]++;
            end
        end
    endtask

    typedef struct {
        logic        rn;
        logic        v;
        logic [31:0] ins;
        logic [1:0]  ordy;
        logic        exp_rdy;
        logic [2:0]  exp_c0;
        logic [2:0]  exp_c1;
        logic [31:0] exp_h0;
        logic [31:0] exp_h1;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic [31:0] ins;
        logic [31:0] x;

        // Override placement, a mid-stream reset, then balancing of independent instructions.
        tbl[0] = '{1'b0, 1'b0, 32'h0000_0000, 2'b00, 1'b0, 3'd0, 3'd0, 32'h0, 32'h0};
        tbl[1] = '{1'b1, 1'b1, 32'h1000_0201, 2'b00, 1'b1, 3'd1, 3'd0, 32'h1000_0201, 32'h0};
        tbl[2] = '{1'b1, 1'b1, 32'h1800_0000, 2'b00, 1'b1, 3'd1, 3'd1, 32'h1000_0201, 32'h1800_0000};
        tbl[3] = '{1'b0, 1'b1, 32'h0000_2021, 2'b00, 1'b0, 3'd0, 3'd0, 32'h0, 32'h0};
        tbl[4] = '{1'b1, 1'b1, 32'h0000_2011, 2'b00, 1'b1, 3'd1, 3'd0, 32'h0000_2011, 32'h0};
        tbl[5] = '{1'b1, 1'b1, 32'h0000_2413, 2'b00, 1'b1, 3'd1, 3'd1, 32'h0000_2011, 32'h0000_2413};
        tbl[6] = '{1'b1, 1'b1, 32'h0000_2815, 2'b00, 1'b1, 3'd2, 3'd1, 32'h0000_2011, 32'h0000_2413};
        tbl[7] = '{1'b1, 1'b1, 32'h0000_2C17, 2'b00, 1'b1, 3'd2, 3'd2, 32'h0000_2011, 32'h0000_2413};

        resetn = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        bus.out_ready = '0;
        for (int k = 0; k < NUM_LANES; k++) mcnt[k] = 0;

        for (int i = 0; i < 8; i++) begin
            apply(tbl[i].rn, tbl[i].v, tbl[i].ins, tbl[i].ordy);
            check($sformatf("tbl%0d in_ready", i), smp_ready, tbl[i].exp_rdy);
            #1;
            check($sformatf("tbl%0d count0", i), bus.lane_count[2:0], tbl[i].exp_c0);
            check($sformatf("tbl%0d count1", i), bus.lane_count[5:3], tbl[i].exp_c1);
            if (tbl[i].exp_c0 != 3'd0) check($sformatf("tbl%0d head0", i), bus.out_instr[31:0], tbl[i].exp_h0);
            if (tbl[i].exp_c1 != 3'd0) check($sformatf("tbl%0d head1", i), bus.out_instr[63:32], tbl[i].exp_h1);
        end

        // Dependency beats balance: lane0 holds SRC=1/DST=1 and is fuller, yet gets the dependent instr.
        apply(1'b0, 1'b0, 32'h0, 2'b00);
        apply(1'b1, 1'b1, 32'h1000_0201, 2'b00);
        apply(1'b1, 1'b1, 32'h1000_0403, 2'b00);
        apply(1'b1, 1'b1, 32'h0000_1C01, 2'b00);
        check("dep route ready", smp_ready, 1'b1);
        #1;
        check("dep route counts", bus.lane_count, 6'h03);

        // Cross hazard: stall until lane0's entry is gone (a same-cycle pop still counts).
        apply(1'b0, 1'b0, 32'h0, 2'b00);
        apply(1'b1, 1'b1, 32'h1000_4005, 2'b00);
        apply(1'b1, 1'b1, 32'h1800_4209, 2'b00);
        apply(1'b1, 1'b1, 32'h0000_0A09, 2'b00);
        check("cross stall", smp_stall, 1'b1);
        check("cross not ready", smp_ready, 1'b0);
        apply(1'b1, 1'b1, 32'h0000_0A09, 2'b01);
        check("cross stall during pop", smp_stall, 1'b1);
        apply(1'b1, 1'b1, 32'h0000_0A09, 2'b00);
        check("cross released", smp_ready, 1'b1);
        #1;
        check("cross lands lane1", bus.lane_count, 6'h10);

        // Full lane with a same-cycle pop refuses the push, accepts next cycle.
        apply(1'b0, 1'b0, 32'h0, 2'b00);
        for (int i = 0; i < 4; i++) begin
            ins = 32'h1000_0000 | ((32'h30 + 32'(i)) << 9) | (32'h40 + 32'(i));
            apply(1'b1, 1'b1, ins, 2'b00);
        end
        x = 32'h1000_0000 | (32'h38 << 9) | 32'h48;
        apply(1'b1, 1'b1, x, 2'b01);
        check("full not ready", smp_ready, 1'b0);
        check("full stall", smp_stall, 1'b1);
        #1;
        check("full after pop", bus.lane_count[2:0], 3'd3);
        apply(1'b1, 1'b1, x, 2'b00);
        check("full retry ready", smp_ready, 1'b1);
        #1;
        check("full refilled", bus.lane_count[2:0], 3'd4);

        // Reset with both lanes non-empty discards everything; first accept on the next edge.
        apply(1'b1, 1'b1, 32'h1800_A051, 2'b00);
        apply(1'b0, 1'b1, 32'h0000_0C0D, 2'b00);
        check("reset in_ready", smp_ready, 1'b0);
        check("reset hazard", smp_stall, 1'b0);
        #1;
        check("reset out_valid", bus.out_valid, 2'b00);
        check("reset counts", bus.lane_count, 6'h00);
        apply(1'b1, 1'b1, 32'h0000_0C0D, 2'b00);
        check("post reset ready", smp_ready, 1'b1);
        #1;
        check("post reset valid", bus.out_valid, 2'b01);
        check("post reset head", bus.out_instr[31:0], 32'h0000_0C0D);

        // Random traffic against the model; small address space to provoke hazards.
        for (int n = 0; n < 800; n++) begin
            ins = $urandom;
            ins[17:9] = 9'($urandom_range(0, 7));
            ins[8:0]  = 9'($urandom_range(0, 7));
            ins[28]   = ($urandom_range(0, 3) == 0);
            apply($urandom_range(0, 59) != 0, $urandom_range(0, 4) != 0, ins,
                  {$urandom_range(0, 4) < 2, $urandom_range(0, 4) < 2});
        end
        apply(1'b1, 1'b0, 32'h0, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/instr_dispatch_arbiter.md
INSTR_DISPATCH_ARBITER -- requirements
Module: instr_dispatch_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the instruction width in bits.
REQ-002 Parameter ADDR_W, default 9, SHALL set the source/destination address field width.
REQ-003 Parameter NUM_LANES, default 2, SHALL set the number of output lanes; legal values are 2 and 4.
REQ-004 Parameter DEPTH, default 4, SHALL set the per-lane FIFO depth; it SHALL be a power of 2, at least 2.
REQ-005 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-006 Port resetn, input, 1, SHALL be the reset, synchronous and active-low.
REQ-007 Port in_instr, input, DATA_W, SHALL carry the instruction offered for dispatch.
REQ-008 Port in_valid, input, 1, SHALL mark in_instr as valid.
REQ-009 Port in_ready, output, 1, SHALL indicate the instruction is accepted this cycle.
REQ-010 Port out_instr, output, NUM_LANES*DATA_W, SHALL carry the head of each lane FIFO, with lane k in bits [k*DATA_W +: DATA_W].
REQ-011 Port out_valid, output, NUM_LANES, SHALL flag a non-empty lane.
REQ-012 Port out_ready, input, NUM_LANES, SHALL pop lane k when out_valid[k] and out_ready[k] are both 1.
REQ-013 Port hazard_stall, output, 1, SHALL be 1 when in_valid=1 and in_ready=0.
REQ-014 Port lane_count, output, NUM_LANES*(log2(DEPTH)+1), SHALL report the per-lane occupancy.

Function
REQ-015 Instruction fields SHALL be: OVR = in_instr[28]; LANE = in_instr[27 -: log2(NUM_LANES)]; SRC = in_instr[2*ADDR_W-1:ADDR_W]; DST = in_instr[ADDR_W-1:0]; all other bits pass through untouched.
REQ-016 Each lane SHALL track the SRC and DST of every entry held in its FIFO, to be used for dependency checking.
REQ-017 Lane k SHALL be dependent when the incoming SRC or DST equals any tracked SRC or DST of a valid entry in lane k.
REQ-018 Dependency SHALL be evaluated against the FIFO contents at the start of the cycle; an entry popped in the same cycle still counts.
REQ-019 Routing priority:
- (a) dependent on 2 or more lanes -> stall;
- (b) OVR=1 and LANE is dependent or no lane is dependent -> target LANE;
- (c) OVR=1 and another lane is dependent -> stall;
- (d) exactly one lane is dependent -> target that lane;
- (e) otherwise -> the lane with the lowest count, ties broken by the lowest index.
REQ-020 in_ready SHALL be 1 only when resetn=1, the route is not a stall, and the target lane count < DEPTH; a full target SHALL stall and never redirect.
REQ-021 A full lane SHALL not accept a push even if it is popped in the same cycle.
REQ-022 An accepted instruction SHALL appear at its lane head with out_valid asserted on the next cycle when that lane was empty (1-cycle latency).
REQ-023 Push and pop on a non-full lane in the same cycle SHALL leave the count unchanged and preserve order.
REQ-024 The in_ready/in_instr logic SHALL be combinational from current state and inputs; out_instr and out_valid SHALL depend only on registered state.
REQ-025 FIFO read/write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH without overflow or underflow.
REQ-026 A pop on an empty lane SHALL be ignored.

Reset
REQ-027 While resetn=0 at a clock edge, all lane counts and pointers SHALL clear to 0 and all tracking entries SHALL invalidate.
REQ-028 While resetn=0, out_valid SHALL read 0, lane_count 0, in_ready 0 and hazard_stall 0.
REQ-029 Reset asserted mid-operation SHALL discard all buffered instructions.
REQ-030 The first accept after reset is possible on the first edge with resetn=1.

Verification (NUM_LANES=2, DEPTH=4, ADDR_W=9)
REQ-031 Override: instr 0x1000_0201 (OVR=1, LANE=0), then 0x1800_0000 (LANE=1), out_ready=0 -> lane0 head 0x1000_0201 and lane1 head 0x1800_0000, each out_valid after 1 cycle.
REQ-032 Dependency: lane0 holds SRC=1/DST=1; send SRC=0x0E/DST=1 with lane0 count 2 and lane1 count 0 -> routed to lane0, not the emptier lane1.
REQ-033 Balance: empty lanes, four independent instrs -> lanes 0,1,0,1; lane_count 2/2.
REQ-034 Cross hazard: lane0 holds DST=5, lane1 holds DST=9; send SRC=5/DST=9 -> hazard_stall=1, in_ready=0 until one lane pops its entry, then dispatch to the remaining lane.
REQ-035 Full: lane0 holds 4 entries; an override to lane0 with out_ready[0]=1 -> in_ready=0 that cycle, accepted the next cycle; count ends at 4.
REQ-036 Reset: resetn=0 for 1 cycle with both lanes non-empty -> out_valid=00, lane_count=0 the following cycle; previous data never emerges.
